register_file_vector_masked: RTL and testbench

Parametrised successor to the 256-bit vector register file in the decode stage.
- Generalises register count, lane count and lane width.
- Adds per-lane write masking and an optional write-to-read bypass.
- Adds a multi-cycle "clear sweep" engine that zeroes the array one register per cycle, with a busy/ready handshake.
- Feeds the vector execute stage through two asynchronous read ports.

---
 rtl/vregfile_pkg.sv | 27 ++
 rtl/vregfile_clear_seq.sv | 55 +++++
 rtl/register_file_vector_masked.sv | 91 +++++++++
 tb/tb_register_file_vector_masked.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vregfile_pkg.sv
// Shared definitions for the masked vector register file: default sizes,
// the clear-sweep state type and the lane-merge helper.
package vregfile_pkg;

  localparam int unsigned NUM_REGS_DEF = 8;
  localparam int unsigned LANES_DEF    = 8;
  localparam int unsigned LANE_W_DEF   = 32;

  // Widest register word the merge helper supports (LANES*LANE_W).
  localparam int unsigned VEC_W_MAX    = 4096;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } vrf_state_t;

  // Bits set in mask take the new word, the rest keep the old one.
  // Callers expand their per-lane mask to a per-bit mask first.
  function automatic logic [VEC_W_MAX-1:0] lane_merge(
    input logic [VEC_W_MAX-1:0] old_v,
    input logic [VEC_W_MAX-1:0] new_v,
    input logic [VEC_W_MAX-1:0] mask
  );
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/vregfile_clear_seq.sv
// Clear-sweep engine: walks a pointer over every register, one per cycle,
// and reports busy while the sweep is in flight.
module vregfile_clear_seq
  import vregfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  vrf_state_t        state;
  logic [ADDR_W-1:0] ptr;

  // clr_req is only sampled in IDLE, so requests during a sweep are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= SWEEP;
            ptr   <= '0;
          end
        end
        SWEEP: begin
          if (ptr == LAST_ADDR) begin
            state <= IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign clr_busy = (state == SWEEP);
  assign clr_we   = (state == SWEEP);
  assign clr_addr = ptr;

endmodule

// File: rtl/register_file_vector_masked.sv
// Parametrised vector register file with per-lane write masking, two
// asynchronous read ports and a clear sweep. Define VREGFILE_BYPASS_EN to
// forward an accepted write to a same-address read in the same cycle.
module register_file_vector_masked
  import vregfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned LANES    = LANES_DEF,
  parameter int unsigned LANE_W   = LANE_W_DEF,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       a1,
  input  logic [ADDR_W-1:0]       a2,
  input  logic [ADDR_W-1:0]       a3,
  input  logic [LANES*LANE_W-1:0] wd3,
  input  logic                    we3,
  input  logic [LANES-1:0]        wmask3,
  input  logic                    clr_req,
  output logic                    wr_ready,
  output logic                    clr_busy,
  output logic [LANES*LANE_W-1:0] rd1,
  output logic [LANES*LANE_W-1:0] rd2
);

  localparam int unsigned VEC_W = LANES * LANE_W;

  logic [VEC_W-1:0]  mem [NUM_REGS];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              a1_ok, a2_ok, a3_ok;
  logic              wr_acc;
  logic [VEC_W-1:0]  bit_mask;
  logic [VEC_W-1:0]  old_a3;
  logic [VEC_W-1:0]  merged;
  logic [VEC_W-1:0]  arr_rd1, arr_rd2;

  vregfile_clear_seq #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_ready = ~clr_busy;

  // Non-power-of-two register counts leave unused addresses that must be ignored.
  assign a1_ok  = 32'(a1) < NUM_REGS;
  assign a2_ok  = 32'(a2) < NUM_REGS;
  assign a3_ok  = 32'(a3) < NUM_REGS;
  assign wr_acc = we3 && wr_ready && a3_ok;

  for (genvar i = 0; i < LANES; i++) begin : g_mask
    assign bit_mask[i*LANE_W +: LANE_W] = {LANE_W{wmask3[i]}};
  end

  assign old_a3 = a3_ok ? mem[a3] : '0;
  assign merged = VEC_W'(lane_merge(VEC_W_MAX'(old_a3), VEC_W_MAX'(wd3),
                                    VEC_W_MAX'(bit_mask)));

  // Sweep and write never coincide: writes are only accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[a3] <= merged;
    end
  end

  assign arr_rd1 = a1_ok ? mem[a1] : '0;
  assign arr_rd2 = a2_ok ? mem[a2] : '0;

`ifdef VREGFILE_BYPASS_EN
  assign rd1 = (wr_acc && (a1 == a3)) ? merged : arr_rd1;
  assign rd2 = (wr_acc && (a2 == a3)) ? merged : arr_rd2;
`else
  assign rd1 = arr_rd1;
  assign rd2 = arr_rd2;
`endif

endmodule

// File: tb/tb_register_file_vector_masked.sv
// Directed bench for register_file_vector_masked: a vector table for the
// masked write path plus sequences for sweep, collision, bypass, reset, range.
module tb_register_file_vector_masked;

  localparam int unsigned VW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    a1, a2, a3;
  logic [VW-1:0] wd3;
  logic          we3;
  logic [7:0]    wmask3;
  logic          clr_req;
  logic          wr_ready, clr_busy;
  logic [VW-1:0] rd1, rd2;

  logic [2:0]    b_a1, b_a2, b_a3;
  logic [VW-1:0] b_wd3;
  logic          b_we3;
  logic [7:0]    b_wmask3;
  logic          b_clr_req;
  logic          b_wr_ready, b_clr_busy;
  logic [VW-1:0] b_rd1, b_rd2;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  always #10 clk = ~clk;

  register_file_vector_masked #(.NUM_REGS(8), .LANES(8), .LANE_W(32)) dut (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3), .we3(we3),
    .wmask3(wmask3), .clr_req(clr_req), .wr_ready(wr_ready),
    .clr_busy(clr_busy), .rd1(rd1), .rd2(rd2)
  );

  register_file_vector_masked #(.NUM_REGS(6), .LANES(8), .LANE_W(32)) dut6 (
    .clk(clk), .rst(rst), .a1(b_a1), .a2(b_a2), .a3(b_a3), .wd3(b_wd3),
    .we3(b_we3), .wmask3(b_wmask3), .clr_req(b_clr_req),
    .wr_ready(b_wr_ready), .clr_busy(b_clr_busy), .rd1(b_rd1), .rd2(b_rd2)
  );

  typedef struct {
    logic          we;
    logic [2:0]    wa;
    logic [VW-1:0] wd;
    logic [7:0]    mask;
    logic [2:0]    ra1;
    logic [2:0]    ra2;
    logic [VW-1:0] e1;
    logic [VW-1:0] e2;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [VW-1:0] fill(input logic [31:0] w);
    return {8{w}};
  endfunction

  function automatic logic [VW-1:0] mix(input logic [7:0] m, input logic [31:0] hi,
                                        input logic [31:0] lo);
    logic [VW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = m[i] ? hi : lo;
    return r;
  endfunction

  function automatic vec_t mkv(input logic we, input logic [2:0] wa, input logic [VW-1:0] wd,
                               input logic [7:0] mask, input logic [2:0] ra1,
                               input logic [2:0] ra2, input logic [VW-1:0] e1,
                               input logic [VW-1:0] e2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.mask = mask;
    v.ra1 = ra1; v.ra2 = ra2; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [VW-1:0] data);
    @(negedge clk);
    we3 = 1'b1; a3 = addr; wd3 = data; wmask3 = 8'hFF;
    @(posedge clk);
    #1 we3 = 1'b0;
  endtask

  initial begin
    logic [VW-1:0] mix3, c3x, exp_v;
    int cnt;

    rst = 1'b1; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; we3 = 1'b0; wmask3 = '0; clr_req = 1'b0;
    b_a1 = '0; b_a2 = '0; b_a3 = '0; b_wd3 = '0; b_we3 = 1'b0; b_wmask3 = '0; b_clr_req = 1'b0;

    mix3 = mix(8'h0F, 32'h5555_5555, 32'hAAAA_AAAA);
    c3x  = mix(8'h81, 32'h0000_00C3, 32'h0);
    tbl[0] = mkv(1'b0, 3'd0, '0, 8'h00, 3'd0, 3'd7, '0, '0);
    tbl[1] = mkv(1'b1, 3'd3, fill(32'hAAAA_AAAA), 8'hFF, 3'd0, 3'd1, '0, '0);
    tbl[2] = mkv(1'b0, 3'd3, '0, 8'h00, 3'd3, 3'd2, fill(32'hAAAA_AAAA), '0);
    tbl[3] = mkv(1'b1, 3'd3, fill(32'h5555_5555), 8'h0F, 3'd1, 3'd2, '0, '0);
    tbl[4] = mkv(1'b1, 3'd0, fill(32'h0000_00C3), 8'h81, 3'd3, 3'd5, mix3, '0);
    tbl[5] = mkv(1'b1, 3'd3, fill(32'hFFFF_FFFF), 8'h00, 3'd3, 3'd0, mix3, c3x);
    tbl[6] = mkv(1'b0, 3'd3, fill(32'hFFFF_FFFF), 8'hFF, 3'd3, 3'd0, mix3, c3x);

    @(negedge clk);
    @(negedge clk);
    check("reset_busy", VW'(clr_busy), '0);
    check("reset_ready", VW'(wr_ready), VW'(1));
    rst = 1'b0;

    // Masked-write vector table; each write lands at the following posedge.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      we3 = tbl[i].we; a3 = tbl[i].wa; wd3 = tbl[i].wd; wmask3 = tbl[i].mask;
      a1 = tbl[i].ra1; a2 = tbl[i].ra2;
      #1;
      check($sformatf("vec%0d_rd1", i), rd1, tbl[i].e1);
      check($sformatf("vec%0d_rd2", i), rd2, tbl[i].e2);
    end
    @(negedge clk);
    we3 = 1'b0;

    // Full sweep over a filled array.
    for (int r = 0; r < 8; r++) write_reg(3'(r), fill(32'h100 + 32'(r)));
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    #1 clr_req = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check($sformatf("sweep%0d_busy", n), VW'(clr_busy), VW'(1));
      check($sformatf("sweep%0d_ready", n), VW'(wr_ready), '0);
      for (int r = 0; r < 8; r++) begin
        a1 = 3'(r);
        #1;
        exp_v = (r < n - 1) ? '0 : fill(32'h100 + 32'(r));
        check($sformatf("sweep%0d_r%0d", n, r), rd1, exp_v);
      end
    end
    @(negedge clk);
    check("sweep_end_busy", VW'(clr_busy), '0);
    check("sweep_end_ready", VW'(wr_ready), VW'(1));
    for (int r = 0; r < 8; r++) begin
      a1 = 3'(r);
      #1 check($sformatf("sweep_end_r%0d", r), rd1, '0);
    end

    // Write colliding with clr_req, then writes and held clr_req during the sweep.
    @(negedge clk);
    clr_req = 1'b1; we3 = 1'b1; a3 = 3'd7; wd3 = fill(32'h1234_5678); wmask3 = 8'hFF;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      a1 = 3'd7; a2 = 3'd2; a3 = 3'd2; wd3 = fill(32'hDEAD_BEEF);
      we3 = (n < 8); clr_req = (n < 5);
      #1;
      check($sformatf("coll%0d_busy", n), VW'(clr_busy), VW'(1));
      check($sformatf("coll%0d_r7", n), rd1, fill(32'h1234_5678));
      check($sformatf("coll%0d_r2", n), rd2, '0);
    end
    @(negedge clk);
    #1;
    check("coll_end_busy", VW'(clr_busy), '0);
    check("coll_end_r7", rd1, '0);
    check("coll_end_r2", rd2, '0);

    // Same-cycle read of a masked write.
    write_reg(3'd2, fill(32'h1111_1111));
    @(negedge clk);
    a1 = 3'd2; a2 = 3'd2; a3 = 3'd2; we3 = 1'b1; wd3 = fill(32'h2222_2222); wmask3 = 8'hF0;
    #1;
`ifdef VREGFILE_BYPASS_EN
    exp_v = mix(8'hF0, 32'h2222_2222, 32'h1111_1111);
`else
    exp_v = fill(32'h1111_1111);
`endif
    check("bypass_rd1", rd1, exp_v);
    check("bypass_rd2", rd2, exp_v);
    @(posedge clk);
    #1 we3 = 1'b0;
    @(negedge clk);
    check("bypass_after", rd1, mix(8'hF0, 32'h2222_2222, 32'h1111_1111));

    // Reset in the third sweep cycle, then a fresh sweep.
    write_reg(3'd5, fill(32'h5A5A_5A5A));
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    #1 clr_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_busy", VW'(clr_busy), '0);
    check("rstmid_ready", VW'(wr_ready), VW'(1));
    for (int r = 0; r < 8; r++) begin
      a1 = 3'(r);
      #1 check($sformatf("rstmid_r%0d", r), rd1, '0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    #1 clr_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!clr_busy) break;
      cnt++;
    end
    check("fresh_sweep_len", VW'(cnt), VW'(8));

    // Out-of-range addresses on the six-register instance.
    @(negedge clk);
    b_we3 = 1'b1; b_a3 = 3'd5; b_wd3 = fill(32'hCAFE_0005); b_wmask3 = 8'hFF;
    @(negedge clk);
    b_a3 = 3'd7; b_wd3 = fill(32'hFFFF_FFFF);
    @(negedge clk);
    b_a3 = 3'd6;
    @(negedge clk);
    b_we3 = 1'b0;
    for (int r = 0; r < 8; r++) begin
      b_a1 = 3'(r);
      #1 check($sformatf("range_r%0d", r), b_rd1, (r == 5) ? fill(32'hCAFE_0005) : '0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
